spi_mcp4822_dac: RTL

Stereo audio-output SPI transmitter for an MCP4822 dual 12-bit DAC; the transmit-direction counterpart of the MCP3202 ADC capture path. It accepts one left/right sample pair per valid/ready handshake and serialises two 16-bit command frames (channel A, then channel B) in SPI mode 0. It then pulses LDAC so both DAC outputs update together. It sits in the audio clock domain (`clk_135_w`) beside the ADC capture and low-pass filter.

---
 rtl/spi_dac_pkg.sv | 23 ++
 rtl/spi_tick_gen.sv | 21 ++
 rtl/spi_mcp4822_dac.sv | 89 ++++++++
 3 files changed

// File: rtl/spi_dac_pkg.sv
// spi_dac_pkg: FSM states, MCP4822 command-frame layout and frame builder.
package spi_dac_pkg;

    typedef enum logic [2:0] {IDLE, SHIFT_A, GAP_A, SHIFT_B, GAP_B, LDAC} dac_state_t;

    localparam int FRAME_BITS = 16;
    localparam int SEL_BIT    = 15;
    localparam int BUF_BIT    = 14;
    localparam int GA_N_BIT   = 13;
    localparam int SHDN_N_BIT = 12;

    function automatic logic [FRAME_BITS-1:0] make_frame(input logic sel, input logic gain_2x,
                                                         input logic shdn_n, input logic [11:0] data);
        logic [FRAME_BITS-1:0] f;
        f = {4'b0, data};
        f[SEL_BIT]    = sel;
        f[BUF_BIT]    = 1'b0;
        f[GA_N_BIT]   = ~gain_2x;
        f[SHDN_N_BIT] = shdn_n;
        return f;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: one-cycle tick every CLK_DIV cycles, restarted by clear.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(CLK_DIV);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(CLK_DIV - 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else          cnt <= (clear || tick) ? '0 : cnt + W'(1);

endmodule

// File: rtl/spi_mcp4822_dac.sv
// spi_mcp4822_dac: serialises a stereo sample pair as two MCP4822 SPI mode-0 frames, then pulses LDAC.
module spi_mcp4822_dac
    import spi_dac_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [11:0] i_left,
    input  logic [11:0] i_right,
    input  logic        i_gain_2x,
    input  logic        i_shdn_n,
    output logic        o_sck,
    output logic        o_mosi,
    output logic        o_cs_n,
    output logic        o_ldac_n,
    output logic        o_busy
);

    dac_state_t            state, state_n;
    logic                  tick, clear, accept, shifting, last;
    logic [FRAME_BITS-1:0] sr;
    logic [4:0]            half;
    logic                  sck_q;
    logic [11:0]           right_q;
    logic                  gain_q, shdn_q;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (clear),
        .tick   (tick)
    );

    assign accept   = i_valid && state == IDLE;
    assign shifting = state == SHIFT_A || state == SHIFT_B;
    assign last     = shifting && tick && half == 5'd31;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_n;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = accept ? SHIFT_A : IDLE;
            SHIFT_A: state_n = last   ? GAP_A   : SHIFT_A;
            GAP_A:   state_n = tick   ? SHIFT_B : GAP_A;
            SHIFT_B: state_n = last   ? GAP_B   : SHIFT_B;
            GAP_B:   state_n = tick   ? LDAC    : GAP_B;
            LDAC:    state_n = tick   ? IDLE    : LDAC;
            default: state_n = IDLE;
        endcase
        // every state entry restarts the tick phase so all timing counts from entry
        clear = state_n != state || state == IDLE;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sr      <= '0;
            half    <= '0;
            sck_q   <= 1'b0;
            right_q <= '0;
            gain_q  <= 1'b0;
            shdn_q  <= 1'b0;
        end else begin
            half  <= clear ? 5'd0 : half + 5'(tick);
            sck_q <= clear ? 1'b0 : sck_q ^ (shifting && tick);
            if (accept) begin
                sr      <= make_frame(1'b0, i_gain_2x, i_shdn_n, i_left);
                right_q <= i_right;
                gain_q  <= i_gain_2x;
                shdn_q  <= i_shdn_n;
            end else if (state == GAP_A && tick)
                sr <= make_frame(1'b1, gain_q, shdn_q, right_q);
            else if (shifting && tick && sck_q)
                sr <= {sr[FRAME_BITS-2:0], 1'b0};
        end

    assign o_ready  = state == IDLE;
    assign o_busy   = ~o_ready;
    assign o_cs_n   = ~shifting;
    assign o_sck    = sck_q;
    assign o_mosi   = shifting && sr[FRAME_BITS-1];
    assign o_ldac_n = state != LDAC;

endmodule
